// File: rtl/control_sequencer.sv
// Fetch/execute control FSM for the 16-bit CPU.
// Sequences ROM instruction fetch, opcode decode and ALU/branch/load/store execution,
// driving datapath strobes and the dev/opaddr/ldstr control-bus fields. Moore machine:
// every output decodes from the state register, except op1_to_pc in BCOND, which also
// looks at acc_zero because that flag is only valid during BCOND.
module control_sequencer #(
    parameter int unsigned WORD_W = 16
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       run,
    input  logic [3:0] ir_op,
    input  logic       acc_zero,
    input  logic       mem_ready,
    output logic [1:0] dev,
    output logic [3:0] opaddr,
    output logic       ldstr,
    output logic       pc_to_mar,
    output logic       pc_inc,
    output logic       mar_to_bus,
    output logic       rom_rd,
    output logic       ram_rd,
    output logic       ram_wr,
    output logic       mdr_ld,
    output logic       mdr_to_ir,
    output logic       op0_to_acc,
    output logic       alu_en,
    output logic       acc_to_op1,
    output logic       op0_to_pc,
    output logic       op1_to_pc,
    output logic       op0_xor_acc,
    output logic       op0_to_mar,
    output logic       mdr_to_op1,
    output logic       op1_to_mdr,
    output logic       instr_done,
    output logic [4:0] state
);

    // The data bus is only carried through; a bus narrower than an opcode nibble
    // cannot hold an instruction and is not a supported configuration.
    if (WORD_W < 4) begin : g_word_w_unsupported
    end

    localparam logic [1:0] DevNone = 2'b00;
    localparam logic [1:0] DevRom  = 2'b01;
    localparam logic [1:0] DevRam  = 2'b10;
    localparam logic [1:0] DevReg  = 2'b11;

    typedef enum logic [4:0] {
        StIdle  = 5'd0,
        StF0    = 5'd1,
        StF1    = 5'd2,
        StF2    = 5'd3,
        StDec   = 5'd4,
        StA0    = 5'd5,
        StA1    = 5'd6,
        StA2    = 5'd7,
        StBr    = 5'd8,
        StCmp   = 5'd9,
        StBcond = 5'd10,
        StLa    = 5'd11,
        StLr    = 5'd12,
        StLo    = 5'd13,
        StLf    = 5'd14,
        StS0    = 5'd15,
        StS1    = 5'd16
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] op_q;
    state_e     after_term;
    logic       bcond_take;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode latch: execute states must not see IR changes after decode.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            op_q <= 4'h0;
        end else if (state_q == StDec) begin
            op_q <= ir_op;
        end
    end

    // Branch condition: BEQ on zero, BNE on non-zero, BGT/BLT unconditional for now.
    always_comb begin
        bcond_take = 1'b1;
        if (op_q == 4'h9) begin
            bcond_take = acc_zero;
        end else if (op_q == 4'hA) begin
            bcond_take = ~acc_zero;
        end
        after_term = run ? StF0 : StIdle;
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle:  state_d = run ? StF0 : StIdle;
            StF0:    state_d = StF1;
            StF1:    state_d = mem_ready ? StF2 : StF1;
            StF2:    state_d = StDec;
            StDec: begin
                if (ir_op[3] == 1'b0) begin
                    state_d = StA0;
                end else begin
                    case (ir_op)
                        4'h8:        state_d = StBr;
                        4'h9, 4'hA:  state_d = StCmp;
                        4'hB, 4'hC:  state_d = StBcond;
                        4'hD, 4'hE:  state_d = StLa;
                        default:     state_d = StS0;
                    endcase
                end
            end
            StA0:    state_d = StA1;
            StA1:    state_d = StA2;
            StA2:    state_d = after_term;
            StBr:    state_d = after_term;
            StCmp:   state_d = StBcond;
            StBcond: state_d = after_term;
            StLa:    state_d = (op_q == 4'hD) ? StLr : StLo;
            StLr:    state_d = mem_ready ? StLf : StLr;
            StLo:    state_d = mem_ready ? StLf : StLo;
            StLf:    state_d = after_term;
            StS0:    state_d = StS1;
            StS1:    state_d = mem_ready ? after_term : StS1;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        dev         = DevNone;
        opaddr      = 4'h0;
        ldstr       = 1'b0;
        pc_to_mar   = 1'b0;
        pc_inc      = 1'b0;
        mar_to_bus  = 1'b0;
        rom_rd      = 1'b0;
        ram_rd      = 1'b0;
        ram_wr      = 1'b0;
        mdr_ld      = 1'b0;
        mdr_to_ir   = 1'b0;
        op0_to_acc  = 1'b0;
        alu_en      = 1'b0;
        acc_to_op1  = 1'b0;
        op0_to_pc   = 1'b0;
        op1_to_pc   = 1'b0;
        op0_xor_acc = 1'b0;
        op0_to_mar  = 1'b0;
        mdr_to_op1  = 1'b0;
        op1_to_mdr  = 1'b0;
        instr_done  = 1'b0;
        case (state_q)
            StF0: begin
                pc_to_mar = 1'b1;
                pc_inc    = 1'b1;
            end
            StF1: begin
                mar_to_bus = 1'b1;
                rom_rd     = 1'b1;
                dev        = DevRom;
            end
            StF2: begin
                mdr_ld    = 1'b1;
                mdr_to_ir = 1'b1;
                dev       = DevRom;
            end
            StA0: op0_to_acc = 1'b1;
            StA1: begin
                alu_en = 1'b1;
                dev    = DevReg;
                opaddr = op_q;
            end
            StA2: begin
                acc_to_op1 = 1'b1;
                instr_done = 1'b1;
            end
            StBr: begin
                op0_to_pc  = 1'b1;
                instr_done = 1'b1;
            end
            StCmp: op0_xor_acc = 1'b1;
            StBcond: begin
                op1_to_pc  = bcond_take;
                instr_done = 1'b1;
            end
            StLa: begin
                op0_to_mar = 1'b1;
                mar_to_bus = 1'b1;
            end
            StLr: begin
                ram_rd = 1'b1;
                mdr_ld = 1'b1;
                dev    = DevRam;
            end
            StLo: begin
                rom_rd = 1'b1;
                mdr_ld = 1'b1;
                dev    = DevRom;
            end
            StLf: begin
                mdr_to_op1 = 1'b1;
                instr_done = 1'b1;
            end
            StS0: begin
                op0_to_mar = 1'b1;
                op1_to_mdr = 1'b1;
                mar_to_bus = 1'b1;
                dev        = DevRam;
                ldstr      = 1'b1;
            end
            StS1: begin
                ram_wr     = 1'b1;
                dev        = DevRam;
                ldstr      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction runs plus random traffic,
// checked cycle by cycle against a phase-list model of the instruction flow.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       n_reset, run, acc_zero, mem_ready;
    logic [3:0] ir_op;
    logic [1:0] dev;
    logic [3:0] opaddr;
    logic       ldstr, pc_to_mar, pc_inc, mar_to_bus, rom_rd, ram_rd, ram_wr, mdr_ld, mdr_to_ir;
    logic       op0_to_acc, alu_en, acc_to_op1, op0_to_pc, op1_to_pc, op0_xor_acc;
    logic       op0_to_mar, mdr_to_op1, op1_to_mdr, instr_done;
    logic [4:0] state;

    control_sequencer #(.WORD_W(16)) dut (
        .clock(clock), .n_reset(n_reset), .run(run), .ir_op(ir_op), .acc_zero(acc_zero),
        .mem_ready(mem_ready), .dev(dev), .opaddr(opaddr), .ldstr(ldstr),
        .pc_to_mar(pc_to_mar), .pc_inc(pc_inc), .mar_to_bus(mar_to_bus), .rom_rd(rom_rd),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .mdr_ld(mdr_ld), .mdr_to_ir(mdr_to_ir),
        .op0_to_acc(op0_to_acc), .alu_en(alu_en), .acc_to_op1(acc_to_op1),
        .op0_to_pc(op0_to_pc), .op1_to_pc(op1_to_pc), .op0_xor_acc(op0_xor_acc),
        .op0_to_mar(op0_to_mar), .mdr_to_op1(mdr_to_op1), .op1_to_mdr(op1_to_mdr),
        .instr_done(instr_done), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] dev;
        logic [3:0] opaddr;
        logic ldstr, pc_to_mar, pc_inc, mar_to_bus, rom_rd, ram_rd, ram_wr, mdr_ld, mdr_to_ir;
        logic op0_to_acc, alu_en, acc_to_op1, op0_to_pc, op1_to_pc, op0_xor_acc;
        logic op0_to_mar, mdr_to_op1, op1_to_mdr, instr_done;
    } outs_t;

    outs_t obs;
    assign obs = {dev, opaddr, ldstr, pc_to_mar, pc_inc, mar_to_bus, rom_rd, ram_rd, ram_wr,
                  mdr_ld, mdr_to_ir, op0_to_acc, alu_en, acc_to_op1, op0_to_pc, op1_to_pc,
                  op0_xor_acc, op0_to_mar, mdr_to_op1, op1_to_mdr, instr_done};

    // Model phases (bench-private numbering).
    localparam int P_IDLE = 0,  P_F0 = 1,  P_F1 = 2,  P_F2 = 3,  P_DEC = 4;
    localparam int P_A0   = 10, P_A1 = 11, P_A2 = 12, P_BR = 13, P_CMP = 14, P_BC = 15;
    localparam int P_LA   = 16, P_LR = 17, P_LO = 18, P_LF = 19, P_S0 = 20, P_S1 = 21;

    int         checks = 0;
    int         failures = 0;
    int         cur = P_IDLE;
    int         pq[$];
    logic [3:0] m_op = 4'h0;
    int         cyc;

    function automatic bit is_wait(int ph);
        return (ph == P_F1) || (ph == P_LR) || (ph == P_LO) || (ph == P_S1);
    endfunction

    function automatic outs_t exp_outs(int ph, logic [3:0] op, logic az);
        outs_t e;
        e = '0;
        case (ph)
            P_F0:  begin e.pc_to_mar = 1; e.pc_inc = 1; end
            P_F1:  begin e.mar_to_bus = 1; e.rom_rd = 1; e.dev = 2'b01; end
            P_F2:  begin e.mdr_ld = 1; e.mdr_to_ir = 1; e.dev = 2'b01; end
            P_A0:  e.op0_to_acc = 1;
            P_A1:  begin e.alu_en = 1; e.dev = 2'b11; e.opaddr = op; end
            P_A2:  begin e.acc_to_op1 = 1; e.instr_done = 1; end
            P_BR:  begin e.op0_to_pc = 1; e.instr_done = 1; end
            P_CMP: e.op0_xor_acc = 1;
            P_BC:  begin
                e.op1_to_pc  = (op == 4'h9) ? az : ((op == 4'hA) ? ~az : 1'b1);
                e.instr_done = 1;
            end
            P_LA:  begin e.op0_to_mar = 1; e.mar_to_bus = 1; end
            P_LR:  begin e.ram_rd = 1; e.mdr_ld = 1; e.dev = 2'b10; end
            P_LO:  begin e.rom_rd = 1; e.mdr_ld = 1; e.dev = 2'b01; end
            P_LF:  begin e.mdr_to_op1 = 1; e.instr_done = 1; end
            P_S0:  begin
                e.op0_to_mar = 1; e.op1_to_mdr = 1; e.mar_to_bus = 1;
                e.dev = 2'b10; e.ldstr = 1;
            end
            P_S1:  begin e.ram_wr = 1; e.dev = 2'b10; e.ldstr = 1; e.instr_done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (is_wait(cur) && !mem_ready) return;
        if (cur == P_IDLE) begin
            if (run) begin cur = P_F0; pq = '{P_F1, P_F2, P_DEC}; end
        end else if (cur == P_DEC) begin
            m_op = ir_op;
            if (m_op < 4'h8)                      pq = '{P_A0, P_A1, P_A2};
            else if (m_op == 4'h8)                pq = '{P_BR};
            else if (m_op == 4'h9 || m_op == 4'hA) pq = '{P_CMP, P_BC};
            else if (m_op == 4'hB || m_op == 4'hC) pq = '{P_BC};
            else if (m_op == 4'hD)                pq = '{P_LA, P_LR, P_LF};
            else if (m_op == 4'hE)                pq = '{P_LA, P_LO, P_LF};
            else                                  pq = '{P_S0, P_S1};
            cur = pq.pop_front();
        end else if (pq.size() == 0) begin
            if (run) begin cur = P_F0; pq = '{P_F1, P_F2, P_DEC}; end
            else cur = P_IDLE;
        end else begin
            cur = pq.pop_front();
        end
    endtask

    task automatic check_outs(input string tag, input outs_t e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // One clock: apply inputs, step the model, sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic [3:0] op, input logic az, input logic mr,
                         input string tag);
        run = r; ir_op = op; acc_zero = az; mem_ready = mr;
        model_step();
        @(posedge clock);
        #1;
        check_outs(tag, exp_outs(cur, m_op, acc_zero));
        if (cur == P_IDLE) check_int({tag, " idle state"}, int'(state), 0);
    endtask

    // Run one instruction; ir_op is scrambled outside DEC to exercise the opcode latch.
    task automatic do_instr(input logic [3:0] op, input logic az, input int waits,
                            input bit stop_in_a1, input string tag, output int n);
        int         left;
        bit         done;
        logic       mr, r;
        logic [3:0] opd;
        left = waits;
        done = 0;
        n = 0;
        while (!done && n < 40) begin
            mr = 1'b1;
            if (left > 0 && (cur == P_LR || cur == P_LO || cur == P_S1)) begin
                mr = 1'b0;
                left--;
            end
            opd = (cur == P_DEC) ? op : ~op;
            r = !(stop_in_a1 && (cur == P_A1 || cur == P_A2));
            cycle(r, opd, az, mr, tag);
            n++;
            if (instr_done) done = 1;
        end
    endtask

    initial begin
        n_reset = 1'b0; run = 1'b0; ir_op = 4'h0; acc_zero = 1'b0; mem_ready = 1'b0;
        #12;
        check_outs("reset outputs", '0);
        check_int("reset state", int'(state), 0);
        @(posedge clock);
        #1;
        n_reset = 1'b1;

        do_instr(4'h3, 1'b0, 0, 0, "alu op3", cyc);  check_int("alu latency", cyc, 7);
        do_instr(4'h9, 1'b1, 0, 0, "beq taken", cyc); check_int("beq latency", cyc, 6);
        do_instr(4'h9, 1'b0, 0, 0, "beq not taken", cyc);
        do_instr(4'hA, 1'b1, 0, 0, "bne not taken", cyc);
        do_instr(4'hA, 1'b0, 0, 0, "bne taken", cyc); check_int("bne latency", cyc, 6);
        do_instr(4'h8, 1'b0, 0, 0, "br", cyc);        check_int("br latency", cyc, 5);
        do_instr(4'hB, 1'b0, 0, 0, "bgt", cyc);       check_int("bgt latency", cyc, 5);
        do_instr(4'hC, 1'b1, 0, 0, "blt", cyc);       check_int("blt latency", cyc, 5);
        do_instr(4'hE, 1'b0, 3, 0, "ld rom wait", cyc); check_int("ld rom wait latency", cyc, 10);
        do_instr(4'hD, 1'b0, 0, 0, "ld ram", cyc);    check_int("ld ram latency", cyc, 7);
        do_instr(4'hD, 1'b0, 2, 0, "ld ram wait", cyc); check_int("ld ram wait latency", cyc, 9);
        do_instr(4'hF, 1'b0, 0, 0, "st ram", cyc);    check_int("st latency", cyc, 6);
        do_instr(4'h5, 1'b0, 0, 1, "alu run drop", cyc); check_int("alu stop latency", cyc, 7);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "stop to idle");
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "stay idle");

        // Asynchronous reset while waiting in F1.
        cycle(1'b1, 4'h0, 1'b0, 1'b0, "pre-reset f0");
        cycle(1'b1, 4'h0, 1'b0, 1'b0, "pre-reset f1");
        cycle(1'b1, 4'h0, 1'b0, 1'b0, "pre-reset f1 hold");
        #2;
        n_reset = 1'b0;
        cur = P_IDLE;
        pq.delete();
        #1;
        check_outs("async reset outputs", '0);
        check_int("async reset state", int'(state), 0);
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        cycle(1'b1, 4'h0, 1'b0, 1'b1, "post-reset f0");

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) != 0), 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
